// File: rtl/bitstream_loader_pkg.sv
// Shared state encoding and default timing for the bitstream loader.
package bitstream_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SETUP,
    STROBE,
    HOLD,
    USRRST,
    DONE
  } state_t;

  localparam int DEF_MAX_BYTES    = 16384;
  localparam int DEF_SETUP_CYC    = 2;
  localparam int DEF_HOLD_CYC     = 2;
  localparam int DEF_USER_RST_CYC = 5;
  localparam int FETCH_CYC        = 5;
  localparam logic [7:0] PAD_BYTE = 8'h00;

endpackage

// File: rtl/loader_word_packer.sv
// Captures read bytes one cycle after their request and shifts them into a
// big-endian word; byte slots that were not read are filled with padding.
module loader_word_packer
  import bitstream_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        slot,
  input  logic        rd,
  input  logic [7:0]  din,
  output logic [31:0] word
);

  logic slot_d;
  logic rd_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_d <= 1'b0;
      rd_d   <= 1'b0;
      word   <= 32'h0;
    end else begin
      slot_d <= slot;
      rd_d   <= rd;
      if (slot_d)
        word <= {word[23:0], (rd_d ? din : PAD_BYTE)};
    end
  end

endmodule

// File: rtl/bitstream_loader.sv
// Streams a byte bitstream from memory into 32-bit fabric config writes,
// then pulses the user reset. Optional running checksum: LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | 4 byte reads + capture of the last byte (5 cycles)
// SETUP  | word stable before strobe
// STROBE | one-cycle config write
// HOLD   | word held after strobe
// USRRST | user reset pulse
// DONE   | one-cycle completion pulse
module bitstream_loader
  import bitstream_loader_pkg::*;
#(
  parameter int MAX_BYTES    = DEF_MAX_BYTES,
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int USER_RST_CYC = DEF_USER_RST_CYC,
  localparam int AW          = $clog2(MAX_BYTES)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [AW:0]   len,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_data,
  output logic [31:0]   SelfWriteData,
  output logic          SelfWriteStrobe,
  output logic          user_rst,
  output logic          busy,
  output logic          done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]   checksum
`endif
);

  localparam logic [AW:0] MAX_L = MAX_BYTES[AW:0];

  state_t      state;
  state_t      next;
  logic [15:0] cnt;
  logic [15:0] cnt_init;
  logic [AW:0] addr;
  logic [AW:0] len_q;
  logic [AW:0] len_clip;
  logic        tc;
  logic        slot;
  logic        accept;

  assign len_clip = (len > MAX_L) ? MAX_L : len;
  assign tc       = (cnt == 16'd0);
  assign mem_addr = addr[AW-1:0];

  always_comb begin
    next            = state;
    slot            = 1'b0;
    mem_rd          = 1'b0;
    accept          = 1'b0;
    SelfWriteStrobe = 1'b0;
    user_rst        = 1'b0;
    done            = 1'b0;
    busy            = (state != IDLE);
    case (state)
      IDLE: begin
        if (start && !abort) begin
          accept = 1'b1;
          next   = (len_clip == '0) ? USRRST : FETCH;
        end
      end
      FETCH: begin
        // Slots past the latched length still take their cycle so every
        // word has the same period, but no read is issued.
        slot   = !tc;
        mem_rd = !tc && (addr < len_q);
        if (tc) next = SETUP;
      end
      SETUP:  if (tc) next = STROBE;
      STROBE: begin
        SelfWriteStrobe = 1'b1;
        next            = HOLD;
      end
      HOLD:   if (tc) next = (addr < len_q) ? FETCH : USRRST;
      USRRST: begin
        user_rst = 1'b1;
        if (tc) next = DONE;
      end
      DONE: begin
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
    if (abort && state != IDLE) next = IDLE;

    cnt_init = 16'd0;
    case (next)
      FETCH:   cnt_init = 16'(FETCH_CYC - 1);
      SETUP:   cnt_init = 16'(SETUP_CYC - 1);
      HOLD:    cnt_init = 16'(HOLD_CYC - 1);
      USRRST:  cnt_init = 16'(USER_RST_CYC - 1);
      default: cnt_init = 16'd0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 16'd0;
      addr  <= '0;
      len_q <= '0;
    end else begin
      state <= next;
      if (next != state)
        cnt <= cnt_init;
      else if (!tc)
        cnt <= cnt - 16'd1;
      if (accept) begin
        addr  <= '0;
        len_q <= len_clip;
      end else if (slot) begin
        addr <= addr + 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge CLK) begin
    if (reset)
      checksum <= 32'h0;
    else if (accept)
      checksum <= 32'h0;
    else if (state == STROBE)
      checksum <= checksum + SelfWriteData;
  end
`endif

  loader_word_packer u_packer (
    .clk   (CLK),
    .reset (reset),
    .slot  (slot),
    .rd    (mem_rd),
    .din   (mem_data),
    .word  (SelfWriteData)
  );

endmodule

// File: tb/tb_bitstream_loader.sv
// Directed bench for bitstream_loader (MAX_BYTES=16); define LOADER_CHECKSUM_EN
// to also exercise the checksum output.
module tb_bitstream_loader;

  localparam int MB = 16;

  logic        CLK = 1'b0;
  logic        reset, start, abort;
  logic [4:0]  len;
  logic        mem_rd;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_data;
  logic [31:0] SelfWriteData;
  logic        SelfWriteStrobe, user_rst, busy, done;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 CLK = ~CLK;

  bitstream_loader #(.MAX_BYTES(MB)) dut (
    .CLK             (CLK),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .len             (len),
    .mem_rd          (mem_rd),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .SelfWriteData   (SelfWriteData),
    .SelfWriteStrobe (SelfWriteStrobe),
    .user_rst        (user_rst),
    .busy            (busy),
    .done            (done)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum        (checksum)
`endif
  );

  logic [7:0] mem [0:15];
  always @(posedge CLK) mem_data <= mem_rd ? mem[mem_addr] : 8'hEE;

  int          cyc = 0, strb_n = 0, ur_n = 0, done_n = 0, rd_n = 0, rd_hi = 0;
  int          ur_last = 0, done_t = 0;
  logic [4:0]  lim = 5'd16;
  logic [31:0] sw [0:255];
  int          st [0:255];
  logic [31:0] hist [0:4095];

  always @(negedge CLK) begin
    cyc <= cyc + 1;
    hist[12'(cyc)] <= SelfWriteData;
    if (SelfWriteStrobe) begin
      sw[8'(strb_n)] <= SelfWriteData;
      st[8'(strb_n)] <= cyc;
      strb_n <= strb_n + 1;
    end
    if (user_rst) begin
      ur_n <= ur_n + 1;
      ur_last <= cyc;
    end
    if (done) begin
      done_n <= done_n + 1;
      done_t <= cyc;
    end
    if (mem_rd) rd_n <= rd_n + 1;
    if (mem_rd && ({1'b0, mem_addr} >= lim)) rd_hi <= rd_hi + 1;
  end

  int errors = 0, checks = 0;
  int b, sc, d0, r0, u0, h0;

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b = strb_n; d0 = done_n; r0 = rd_n; u0 = ur_n; h0 = rd_hi;
  endtask

  task automatic load(input logic [4:0] l);
    lim   = (l > 5'd16) ? 5'd16 : l;
    len   = l;
    start = 1'b1;
    sc    = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_n == d0 && n < budget) begin
      step();
      n++;
    end
    chk("done_seen", done_n - d0, 1);
  endtask

  task automatic wait_strobe(input int target, input int budget);
    int n = 0;
    while (strb_n < target && n < budget) begin
      step();
      n++;
    end
    chk("strobe_seen", strb_n, target);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
    reset = 1'b1; start = 1'b0; abort = 1'b0; len = '0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_strobe", SelfWriteStrobe, 0);
    chk("rst_user_rst", user_rst, 0);
    chk("rst_done", done, 0);
    chk("rst_data", SelfWriteData, 0);
    chk("rst_addr", mem_addr, 0);
    reset = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    // len=8: two full words
    snap(); load(5'd8); wait_done(200);
    chk("a_strobes", strb_n - b, 2);
    chk("a_word0", sw[8'(b)], 32'h01020304);
    chk("a_word1", sw[8'(b + 1)], 32'h05060708);
    chk("a_period", st[8'(b + 1)] - st[8'(b)], 10);
    chk("a_latency", st[8'(b)] - sc, 7);
    chk("a_setup_stable", hist[12'(st[8'(b)] - 2)], 32'h01020304);
    chk("a_hold_stable", hist[12'(st[8'(b)] + 2)], 32'h01020304);
    chk("a_user_rst_len", ur_n - u0, 5);
    chk("a_done_after_urst", done_t - ur_last, 1);
    chk("a_reads", rd_n - r0, 8);
    step();
    chk("a_idle", busy, 0);

    // len=6: padded second word, no reads past 5
    snap(); load(5'd6); wait_done(200);
    chk("b_strobes", strb_n - b, 2);
    chk("b_word0", sw[8'(b)], 32'h01020304);
    chk("b_word1", sw[8'(b + 1)], 32'h05060000);
    chk("b_reads", rd_n - r0, 6);
    chk("b_reads_past_len", rd_hi - h0, 0);
    step();

    // len=0: straight to user reset
    snap(); load(5'd0); wait_done(50);
    chk("c_strobes", strb_n - b, 0);
    chk("c_reads", rd_n - r0, 0);
    chk("c_user_rst_len", ur_n - u0, 5);
    step();

    // abort in second word's SETUP (abort+start together)
    snap(); load(5'd8); wait_strobe(b + 1, 100);
    repeat (8) step();
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk("d_busy_after_abort", busy, 0);
    chk("d_strobe_after_abort", SelfWriteStrobe, 0);
    repeat (30) step();
    chk("d_strobes", strb_n - b, 1);
    chk("d_no_done", done_n - d0, 0);
    chk("d_no_user_rst", ur_n - u0, 0);
    abort = 1'b1; start = 1'b1; len = 5'd8;
    step();
    abort = 1'b0; start = 1'b0;
    chk("d_abort_over_start", busy, 0);
    snap(); load(5'd8); wait_done(200);
    chk("d_reload_strobes", strb_n - b, 2);
    chk("d_reload_word0", sw[8'(b)], 32'h01020304);
    chk("d_reload_word1", sw[8'(b + 1)], 32'h05060708);
    step();

    // start while busy is ignored
    snap(); load(5'd8);
    repeat (3) step();
    len = 5'd20; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(200);
    chk("e_strobes", strb_n - b, 2);
    chk("e_word1", sw[8'(b + 1)], 32'h05060708);
    step();

    // reset during HOLD of first word
    snap(); load(5'd8); wait_strobe(b + 1, 100);
    step();
    chk("e_busy_in_hold", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("e_rst_busy", busy, 0);
    chk("e_rst_data", SelfWriteData, 0);
    chk("e_rst_addr", mem_addr, 0);
    chk("e_rst_mem_rd", mem_rd, 0);
    chk("e_rst_strobe", SelfWriteStrobe, 0);
    chk("e_rst_user_rst", user_rst, 0);
    chk("e_rst_done", done, 0);
    repeat (30) step();
    chk("e_rst_strobes", strb_n - b, 1);
    chk("e_rst_no_done", done_n - d0, 0);

    // len beyond MAX_BYTES clamps to 16 bytes, no wrap
    snap(); load(5'd20); wait_done(300);
    chk("f_strobes", strb_n - b, 4);
    chk("f_word2", sw[8'(b + 2)], 32'h090A0B0C);
    chk("f_word3", sw[8'(b + 3)], 32'h0D0E0F10);
    chk("f_reads", rd_n - r0, 16);
    step();

`ifdef LOADER_CHECKSUM_EN
    for (int i = 0; i < 4; i++) mem[i] = 8'hFF;
    mem[4] = 8'h00; mem[5] = 8'h00; mem[6] = 8'h00; mem[7] = 8'h02;
    snap(); load(5'd8);
    chk("g_checksum_cleared", checksum, 0);
    wait_done(200);
    chk("g_word0", sw[8'(b)], 32'hFFFFFFFF);
    chk("g_word1", sw[8'(b + 1)], 32'h00000002);
    chk("g_checksum", checksum, 32'h00000001);
    repeat (5) step();
    chk("g_checksum_held", checksum, 32'h00000001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitstream_loader.md
BITSTREAM_LOADER -- requirements
Module: bitstream_loader

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 16384, meaning bitstream memory depth in bytes (multiple of 4).
REQ-002 SHALL have parameter SETUP_CYC, default 2, meaning cycles SelfWriteData is stable before strobe.
REQ-003 SHALL have parameter HOLD_CYC, default 2, meaning cycles SelfWriteData is held after strobe.
REQ-004 SHALL have parameter USER_RST_CYC, default 5, meaning length of the post-load user reset pulse.
REQ-005 SHALL have port CLK, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, the reset; it is synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit, a one-cycle load request.
REQ-008 SHALL have port abort, input, 1 bit, which cancels an in-progress load.
REQ-009 SHALL have port len, input, clog2(MAX_BYTES)+1 bits, the byte count sampled on an accepted start.
REQ-010 SHALL have port mem_rd, output, 1 bit, the byte read enable.
REQ-011 SHALL have port mem_addr, output, clog2(MAX_BYTES) bits, the byte address.
REQ-012 SHALL have port mem_data, input, 8 bits, read data valid exactly one cycle after mem_rd.
REQ-013 SHALL have port SelfWriteData, output, 32 bits, the config word to the fabric.
REQ-014 SHALL have port SelfWriteStrobe, output, 1 bit, the config write strobe.
REQ-015 SHALL have port user_rst, output, 1 bit, the user design reset pulse.
REQ-016 SHALL have port busy, output, 1 bit, high whenever the FSM is not IDLE.
REQ-017 SHALL have port done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, SETUP, STROBE, HOLD, USRRST and DONE.
REQ-019 SHALL accept start only in IDLE, latching min(len, MAX_BYTES) and clearing the address to 0; start while busy SHALL be ignored.
REQ-020 In FETCH SHALL issue 4 reads on 4 consecutive cycles (addr a..a+3) and capture the data on the following cycles.
REQ-021 SHALL pack the captured bytes big-endian: byte a goes to bits [31:24], byte a+3 to bits [7:0].
REQ-022 SHALL substitute 0x00 for bytes at address >= latched len and SHALL NOT assert mem_rd for them (partial last word).
REQ-023 SHALL present the word on SelfWriteData for SETUP_CYC cycles, then assert SelfWriteStrobe for exactly 1 cycle, then hold the word HOLD_CYC cycles.
REQ-024 SHALL keep SelfWriteData constant from SETUP entry to HOLD exit.
REQ-025 Per-word period SHALL be 5+SETUP_CYC+1+HOLD_CYC cycles (10 with defaults).
REQ-026 After HOLD, SHALL go to FETCH if the address is below the latched len, otherwise to USRRST.
REQ-027 SHALL assert user_rst for exactly USER_RST_CYC cycles in USRRST.
REQ-028 In DONE SHALL assert done for 1 cycle and return to IDLE.
REQ-029 With len=0, SHALL issue no mem_rd and no strobe and go directly from start to USRRST.
REQ-030 The address counter SHALL NOT wrap; len=MAX_BYTES ends after address MAX_BYTES-1.
REQ-031 abort in any non-IDLE state SHALL drive IDLE the next cycle with strobe, user_rst, mem_rd and done all low, and done SHALL NOT pulse.
REQ-032 abort SHALL take priority over start in the same cycle.

Reset
REQ-033 On reset, SHALL enter IDLE with all outputs 0 (SelfWriteData=0, mem_addr=0).
REQ-034 reset SHALL override abort and start, including mid-load.

Configuration
REQ-035 When LOADER_CHECKSUM_EN is defined, SHALL add output checksum[31:0]: it is cleared on an accepted start, adds each strobed word (mod 2^32), and holds its value until the next start.
REQ-036 When LOADER_CHECKSUM_EN is undefined, the checksum port and logic SHALL be absent.

Structure
REQ-037 The FSM state enum and the default timing constants SHALL live in a shared package, bitstream_loader_pkg.
REQ-038 A sub-module, loader_word_packer (byte capture, zero pad, big-endian shift), SHALL be used; the remainder SHALL stay flat.

Verification
REQ-039 Scenario: len=8, bytes 01..08 -> two strobes with words 0x01020304 and 0x05060708, 10 cycles apart, then user_rst high for 5 cycles, then done pulse.
REQ-040 Scenario: len=6 -> second word 0x0506_0000 with no mem_rd to addresses 6 and 7.
REQ-041 Scenario: len=0 -> no strobe, user_rst 5 cycles, done.
REQ-042 Scenario: abort during the second word's SETUP -> no second strobe, busy low next cycle, no done; a new start then loads correctly.
REQ-043 Scenario: start pulsed while busy, and reset asserted mid-HOLD -> start ignored; reset leaves all outputs 0 and the FSM IDLE.
REQ-044 Scenario: LOADER_CHECKSUM_EN defined, words 0xFFFFFFFF and 0x00000002 -> checksum = 0x00000001.
